// File: rtl/aes_pkg.sv
// aes_pkg: shared definitions for the byte-serial SubBytes/ShiftRows stage.
//   AES_NB_BYTES   bytes per AES-128 state
//   aes_state_e    control FSM states (IDLE / SUB / DONE)
//   byte_of        extracts byte k of a state (byte 0 is the MSB byte)
//   shift_idx      source byte index for (Inv)ShiftRows output byte r+4c
package aes_pkg;

    localparam int AES_NB_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } aes_state_e;

    function automatic logic [7:0] byte_of(input logic [127:0] state, input int k);
        return state[127-8*k -: 8];
    endfunction

    // Forward rotates row r left by r columns, inverse rotates it right.
    function automatic int shift_idx(input int r, input int c, input logic fwd);
        if (fwd) begin
            return r + 4 * ((c + r) % 4);
        end
        return r + 4 * ((c - r + 4) % 4);
    endfunction

endpackage

// File: rtl/aes_shift_rows.sv
// aes_shift_rows: combinational ShiftRows / InvShiftRows byte permutation.
//   fwd_i    1 = ShiftRows, 0 = InvShiftRows
//   state_i  128-bit state, byte k at [127-8k -: 8], k = row + 4*col
//   state_o  permuted state, same byte ordering
module aes_shift_rows
    import aes_pkg::*;
(
    input  logic         fwd_i,
    input  logic [127:0] state_i,
    output logic [127:0] state_o
);

    for (genvar gi = 0; gi < AES_NB_BYTES; gi++) begin : g_byte
        localparam int SRC_F = shift_idx(gi % 4, gi / 4, 1'b1);
        localparam int SRC_I = shift_idx(gi % 4, gi / 4, 1'b0);
        assign state_o[127-8*gi -: 8] = fwd_i ? state_i[127-8*SRC_F -: 8]
                                              : state_i[127-8*SRC_I -: 8];
    end

endmodule

// File: rtl/sbox_combi.sv
// sbox_combi: purely combinational AES S-box / inverse S-box.
//   fwd_i   1 = forward S-box, 0 = inverse S-box
//   byte_i  input byte
//   byte_o  substituted byte
// Built from the GF(2^8) multiplicative inverse plus the affine map rather
// than a lookup table, so one instance covers both directions.
module sbox_combi (
    input  logic       fwd_i,
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // Multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        logic       carry;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            carry = aa[7];
            aa    = {aa[6:0], 1'b0};
            if (carry) aa = aa ^ 8'h1b;
            bb    = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // x^254 == x^-1 for x != 0, and maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] acc;
        p   = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p   = gf_mul(p, p);
            acc = gf_mul(acc, p);
        end
        return acc;
    endfunction

    logic [7:0] inv_in;
    logic [7:0] inv_out;

    always_comb begin
        // Inverse direction undoes the affine map before inverting.
        inv_in  = fwd_i ? byte_i
                        : (rotl(byte_i, 1) ^ rotl(byte_i, 3) ^ rotl(byte_i, 6) ^ 8'h05);
        inv_out = gf_inv(inv_in);
        byte_o  = fwd_i ? (inv_out ^ rotl(inv_out, 1) ^ rotl(inv_out, 2)
                           ^ rotl(inv_out, 3) ^ rotl(inv_out, 4) ^ 8'h63)
                        : inv_out;
    end

endmodule

// File: rtl/aes_subshift_serial.sv
// aes_subshift_serial: byte-serial SubBytes + (Inv)ShiftRows round stage.
// One 128-bit state is accepted per in_valid/in_ready handshake, its bytes
// are substituted LANES per cycle in place, and the (Inv)ShiftRows result is
// offered on out_state under out_valid/out_ready.
//   clk, rst       clock, asynchronous active-high reset
//   in_valid/in_ready/in_en_or_de/in_state   input handshake, mode, state
//   out_valid/out_ready/out_state            output handshake and result
//   busy           FSM not idle
// Parameter LANES (1,2,4,8,16): S-box instances / bytes per cycle.
// Macro AES_SUBSHIFT_OVERLAP_EN: when defined, a new block may be accepted
// on the same edge as the output handshake (no idle bubble).
module aes_subshift_serial
    import aes_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_en_or_de,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int NGROUPS = AES_NB_BYTES / LANES;
    localparam int CNT_W   = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NGROUPS - 1);

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_lanes_check
        $error("aes_subshift_serial: LANES must be 1, 2, 4, 8 or 16");
    end

    aes_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mode_q;
    logic [127:0]     buf_q;
    logic [127:0]     sub_buf_d;
    logic [7:0]       lane_in  [LANES];
    logic [7:0]       lane_out [LANES];
    logic             accept;

    // cnt_q counts groups of LANES bytes; lane gi works on byte cnt*LANES+gi.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign lane_in[gi] = byte_of(buf_q, int'(cnt_q) * LANES + gi);
        sbox_combi u_sbox (
            .fwd_i  (mode_q),
            .byte_i (lane_in[gi]),
            .byte_o (lane_out[gi])
        );
    end

    // Write-back: only the bytes of the current group take an S-box result.
    for (genvar gi = 0; gi < AES_NB_BYTES; gi++) begin : g_wb
        localparam int GRP = gi / LANES;
        localparam int LN  = gi % LANES;
        assign sub_buf_d[127-8*gi -: 8] = (int'(cnt_q) == GRP) ? lane_out[LN]
                                                               : buf_q[127-8*gi -: 8];
    end

`ifdef AES_SUBSHIFT_OVERLAP_EN
    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
`else
    assign in_ready = (state_q == IDLE);
`endif

    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);

    aes_shift_rows u_shift (
        .fwd_i   (mode_q),
        .state_i (buf_q),
        .state_o (out_state)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b1;
            buf_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        buf_q   <= in_state;
                        mode_q  <= in_en_or_de;
                        cnt_q   <= '0;
                        state_q <= SUB;
                    end
                end
                SUB: begin
                    buf_q <= sub_buf_d;
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    // accept can only be true here when overlap is enabled.
                    if (out_ready) begin
                        if (accept) begin
                            buf_q   <= in_state;
                            mode_q  <= in_en_or_de;
                            cnt_q   <= '0;
                            state_q <= SUB;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_subshift_serial.sv
// Bench for aes_subshift_serial: one LANES=1 and one LANES=4 instance,
// known-answer table, random blocks against a reference model, and
// hand-written sequences for backpressure, mode freeze, reset and throughput.
module tb_aes_subshift_serial;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid    [2];
    logic         in_ready    [2];
    logic         in_en_or_de [2];
    logic [127:0] in_state    [2];
    logic         out_valid   [2];
    logic         out_ready   [2];
    logic [127:0] out_state   [2];
    logic         busy        [2];

`ifdef AES_SUBSHIFT_OVERLAP_EN
    localparam int GAP_EXTRA = 1;
`else
    localparam int GAP_EXTRA = 2;
`endif

    always #5 clk = ~clk;

    aes_subshift_serial #(.LANES(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_en_or_de(in_en_or_de[0]), .in_state(in_state[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_state(out_state[0]), .busy(busy[0])
    );

    aes_subshift_serial #(.LANES(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_en_or_de(in_en_or_de[1]), .in_state(in_state[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_state(out_state[1]), .busy(busy[1])
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] sbox_t [256];
    logic [7:0] inv_t  [256];

    typedef struct {
        logic [127:0] din;
        logic         enc;
        logic [127:0] exp;
        string        name;
    } vec_t;
    vec_t vecs [4];

    function automatic int lanes_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    // S-box table from the multiply-by-3 / divide-by-3 generator walk.
    task automatic build_sbox;
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
        for (int i = 0; i < 256; i++) inv_t[sbox_t[i]] = 8'(i);
    endtask

    function automatic logic [127:0] ref_model(input logic [127:0] st, input logic enc);
        logic [7:0]   s [16];
        logic [127:0] res;
        int           src;
        for (int k = 0; k < 16; k++) begin
            s[k] = enc ? sbox_t[st[127-8*k -: 8]] : inv_t[st[127-8*k -: 8]];
        end
        res = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                src = enc ? (c + r) % 4 : (c - r + 4) % 4;
                res[127-8*(r+4*c) -: 8] = s[r + 4*src];
            end
        end
        return res;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_block(input int d, input logic [127:0] data, input logic enc,
                             input logic [127:0] exp, input string name);
        int w;
        int lat;
        in_state[d]    = data;
        in_en_or_de[d] = enc;
        in_valid[d]    = 1'b1;
        w = 0;
        while (!in_ready[d] && w < 50) begin
            tick();
            w++;
        end
        chk({name, " in_ready"}, in_ready[d], 1);
        tick();
        // Scramble inputs after accept: the block must ignore them.
        in_valid[d]    = 1'b0;
        in_en_or_de[d] = ~enc;
        in_state[d]    = ~data;
        lat = 0;
        while (!out_valid[d] && lat < 100) begin
            tick();
            lat++;
        end
        chk({name, " latency"}, lat, 16 / lanes_of(d));
        chk({name, " data"}, out_state[d], exp);
        $display("block %s lanes=%0d enc=%0d in=%h out=%h lat=%0d", name, lanes_of(d), enc, data, out_state[d], lat);
        out_ready[d] = 1'b1;
        tick();
        out_ready[d] = 1'b0;
        chk({name, " released"}, out_valid[d], 0);
    endtask

    task automatic back_to_back(input int d);
        logic [127:0] q_exp [$];
        int           hs_cyc [$];
        logic [127:0] data, cap, e;
        logic         enc, acc, hs;
        int           cyc, nacc;
        cyc  = 0;
        nacc = 0;
        data = {$urandom(), $urandom(), $urandom(), $urandom()};
        enc  = 1'($urandom_range(0, 1));
        in_state[d]    = data;
        in_en_or_de[d] = enc;
        in_valid[d]    = 1'b1;
        out_ready[d]   = 1'b1;
        while (cyc < 300 && hs_cyc.size() < 3) begin
            acc = in_valid[d] && in_ready[d];
            hs  = out_valid[d];
            cap = out_state[d];
            tick();
            cyc++;
            if (hs) begin
                e = (q_exp.size() > 0) ? q_exp.pop_front() : ~cap;
                chk("b2b data", cap, e);
                hs_cyc.push_back(cyc);
                $display("b2b lanes=%0d out=%h cycle=%0d", lanes_of(d), cap, cyc);
            end
            if (acc) begin
                q_exp.push_back(ref_model(data, enc));
                nacc++;
                if (nacc < 3) begin
                    data = {$urandom(), $urandom(), $urandom(), $urandom()};
                    enc  = 1'($urandom_range(0, 1));
                    in_state[d]    = data;
                    in_en_or_de[d] = enc;
                end else begin
                    in_valid[d] = 1'b0;
                end
            end
        end
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b0;
        chk("b2b handshakes", hs_cyc.size(), 3);
        if (hs_cyc.size() >= 3) begin
            chk("b2b gap1", hs_cyc[1] - hs_cyc[0], 16 / lanes_of(d) + GAP_EXTRA);
            chk("b2b gap2", hs_cyc[2] - hs_cyc[1], 16 / lanes_of(d) + GAP_EXTRA);
        end
        tick();
    endtask

    initial begin
        logic [127:0] data, exp;
        int           w;

        build_sbox();
        vecs[0] = '{128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b1, 128'hd4bf5d30e0b452aeb84111f11e2798e5, "fips_enc"};
        vecs[1] = '{128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, "fips_dec"};
        vecs[2] = '{128'h0, 1'b1, {16{8'h63}}, "zero_enc"};
        vecs[3] = '{{16{8'h63}}, 1'b0, 128'h0, "x63_dec"};

        for (int d = 0; d < 2; d++) begin
            in_valid[d]    = 1'b0;
            in_en_or_de[d] = 1'b1;
            in_state[d]    = '0;
            out_ready[d]   = 1'b0;
        end
        rst = 1'b1;
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            chk("reset in_ready", in_ready[d], 1);
            chk("reset out_valid", out_valid[d], 0);
            chk("reset out_state", out_state[d], 0);
            chk("reset busy", busy[d], 0);
        end
        rst = 1'b0;
        tick();

        // Known-answer table on both lane counts.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin
                run_block(d, vecs[i].din, vecs[i].enc, vecs[i].exp, vecs[i].name);
            end
        end

        // Random blocks against the reference model.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 12; i++) begin
                data = {$urandom(), $urandom(), $urandom(), $urandom()};
                w    = int'($urandom_range(0, 1));
                run_block(d, data, 1'(w), ref_model(data, 1'(w)), "random");
            end
        end

        // Backpressure: result held for 10 cycles, new input refused.
        data = {$urandom(), $urandom(), $urandom(), $urandom()};
        exp  = ref_model(data, 1'b1);
        in_state[1] = data; in_en_or_de[1] = 1'b1; in_valid[1] = 1'b1;
        tick();
        in_valid[1] = 1'b0;
        w = 0;
        while (!out_valid[1] && w < 100) begin tick(); w++; end
        chk("bp first", out_state[1], exp);
        in_valid[1] = 1'b1;
        in_state[1] = ~data;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp stable", out_state[1], exp);
            chk("bp in_ready", in_ready[1], 0);
            chk("bp out_valid", out_valid[1], 1);
        end
        in_valid[1] = 1'b0;
        out_ready[1] = 1'b1;
        tick();
        out_ready[1] = 1'b0;
        chk("bp released", out_valid[1], 0);
        chk("bp idle", busy[1], 0);
        $display("backpressure lanes=4 out=%h", exp);

        // Mode toggling during SUB must not affect the latched decrypt mode.
        data = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_state[0] = data; in_en_or_de[0] = 1'b0; in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        w = 0;
        while (!out_valid[0] && w < 100) begin
            in_en_or_de[0] = ~in_en_or_de[0];
            tick();
            w++;
        end
        chk("toggle data", out_state[0], ref_model(data, 1'b0));
        $display("toggle lanes=1 out=%h", out_state[0]);
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;

        // Asynchronous reset with cnt=8 in the LANES=1 instance.
        in_state[0] = data; in_en_or_de[0] = 1'b1; in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        rst = 1'b1;
        #1;
        chk("midrst out_valid", out_valid[0], 0);
        chk("midrst in_ready", in_ready[0], 1);
        chk("midrst busy", busy[0], 0);
        $display("mid-block reset applied");
        tick();
        rst = 1'b0;
        tick();
        run_block(0, vecs[0].din, vecs[0].enc, vecs[0].exp, "after_rst");

        back_to_back(0);
        back_to_back(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
